// File: rtl/barcode_rx.sv
// rtl/barcode_rx.sv - self-calibrating IR barcode receiver producing an 8-bit station ID
// Optional WAIT_FALL/MEAS watchdog enabled by defining BC_TIMEOUT_EN.
module barcode_rx #(
  parameter int               CNT_W   = 22,
  parameter logic [CNT_W-1:0] TMO_CYC = 22'h3F_FFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEAS, WAIT_FALL, SAMPLE} state_t;

  state_t           state, state_nxt;
  logic             bc_m, bc_s, bc_d;
  logic             fall, rise;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] period, period_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             done, done_nxt;
  logic             set_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_m <= 1'b1;
      bc_s <= 1'b1;
      bc_d <= 1'b1;
    end else begin
      bc_m <= BC;
      bc_s <= bc_m;
      bc_d <= bc_s;
    end
  end

  assign fall    = bc_d & ~bc_s;
  assign rise    = ~bc_d & bc_s;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

`ifdef BC_TIMEOUT_EN
  logic [CNT_W-1:0] wd, wd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd <= '0;
    else        wd <= wd_nxt;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    period_nxt  = period;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    done_nxt    = 1'b0;
`ifdef BC_TIMEOUT_EN
    wd_nxt      = fall ? '0 : wd;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = MEAS;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEAS: begin
        if (rise) begin
          period_nxt  = cnt;
          bit_cnt_nxt = 4'd0;
          state_nxt   = WAIT_FALL;
        end
`ifdef BC_TIMEOUT_EN
        else if (cnt == CNT_MAX) state_nxt = IDLE;
`endif
        else if (!bc_s) cnt_nxt = cnt_inc;
      end
      WAIT_FALL: begin
        if (fall) begin
          state_nxt = SAMPLE;
          cnt_nxt   = CNT_W'(1);
        end
`ifdef BC_TIMEOUT_EN
        else if (wd == TMO_CYC) state_nxt = IDLE;
        else wd_nxt = wd + 1'b1;
`endif
      end
      SAMPLE: begin
        // Falls before the sample point are glitches inside the bit and are ignored.
        if (cnt == period) begin
          shift_nxt   = {shift[6:0], bc_s};
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_FALL;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      period  <= period_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      done    <= done_nxt;
    end
  end

  // Station IDs never use the top two bits; anything else is a misread.
  assign set_id = done && (shift[7:6] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID     <= 8'h00;
      ID_vld <= 1'b0;
    end else if (set_id) begin
      ID     <= shift;
      ID_vld <= 1'b1;
    end else if (clr_ID_vld) begin
      ID_vld <= 1'b0;
    end
  end

endmodule
